// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Misses stall the pipeline while the victim line is written back and the new line is refilled.
module dcache_ctrl #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  parameter int TAG_W  = 22
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       p1_addr_i,
  input  logic [31:0]       p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = 32 - TAG_W - IDX_W;
  localparam int WSEL_W = $clog2(LINE_W / 32);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, dirty_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   line_q [LINES];
  logic [31:0]         rdata_q;

  logic [TAG_W-1:0]    req_tag;
  logic [IDX_W-1:0]    idx;
  logic [WSEL_W-1:0]   wsel;
  logic                req, is_load, hit, load_hit, store_hit, fill;
  logic [31:0]         rd_word;
  logic                unused;

  assign req_tag = p1_addr_i[31 -: TAG_W];
  assign idx     = p1_addr_i[OFF_W +: IDX_W];
  assign wsel    = p1_addr_i[2 +: WSEL_W];
  assign unused  = &{1'b0, p1_addr_i[1:0]};

  // Read+write together is a store, so it never counts as a load.
  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign is_load   = p1_MemRead_i & ~p1_MemWrite_i;
  assign hit       = valid_q[idx] & (tag_q[idx] == req_tag);
  assign rd_word   = line_q[idx][{wsel, 5'd0} +: 32];
  assign load_hit  = is_load & hit;
  assign store_hit = (state_q == IDLE) & p1_MemWrite_i & hit;
  assign fill      = (state_q == ALLOCATE) & mem_ack_i;

  assign p1_data_o  = load_hit ? rd_word : rdata_q;
  assign p1_stall_o = rst_i & ((req & ~hit) | (state_q != IDLE));

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      IDLE: begin
        if (req & ~hit)
          state_d = (valid_q[idx] & dirty_q[idx]) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, {OFF_W{1'b0}}};
        mem_data_o   = line_q[idx];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_hit) rdata_q <= rd_word;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      tag_q[idx]  <= req_tag;
      line_q[idx] <= mem_data_i;
    end else if (store_hit) begin
      line_q[idx][{wsel, 5'd0} +: 32] <= p1_data_i;
    end
  end
endmodule
